// File: rtl/seq_shift_unit_pkg.sv
// seq_shift_unit_pkg
//   Shared type definitions for the sequential shift unit.
//   state_t : FSM state encoding (IDLE, SHIFT, DONE).
package seq_shift_unit_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage : seq_shift_unit_pkg

// File: rtl/mux_2x1.sv
// mux_2x1
//   Two-input multiplexer over a 2**N-bit data word.
//   Parameters : N   log2 of data width
//   Ports      : i0  selected when s = 0
//                i1  selected when s = 1
//                s   select
//                y   selected word
module mux_2x1 #(
   parameter int unsigned N = 3
) (
   input  logic [2**N-1:0] i0,
   input  logic [2**N-1:0] i1,
   input  logic            s,
   output logic [2**N-1:0] y
);

   always_comb begin
      y = s ? i1 : i0;
   end

endmodule : mux_2x1

// File: rtl/seq_shift_unit.sv
// seq_shift_unit
//   Multi-cycle logical shifter: shifts an operand by one bit per clock,
//   left or right, for a captured number of cycles.
//   Parameters : N       log2 of data width (W = 2**N)
//   Ports      : clk     rising-edge clock
//                reset   asynchronous active-high reset
//                start   request pulse, accepted only in IDLE
//                num     operand, captured on accepted start
//                shift   shift amount 0..W-1, captured on accepted start
//                select  direction, 0 = logical right, 1 = logical left
//                busy    high while in SHIFT or DONE
//                done    one-cycle completion pulse
//                result  working/final value, held until next accepted start
module seq_shift_unit
   import seq_shift_unit_pkg::*;
#(
   parameter int unsigned N = 3
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [2**N-1:0] num,
   input  logic [N-1:0]    shift,
   input  logic            select,
   output logic            busy,
   output logic            done,
   output logic [2**N-1:0] result
);

   localparam int unsigned W = 2**N;

   state_t         state;
   state_t         state_nxt;
   logic [W-1:0]   data_reg;
   logic [W-1:0]   right_step;
   logic [W-1:0]   left_step;
   logic [W-1:0]   step_val;
   logic [N-1:0]   cnt;
   logic           dir;
   logic           busy_q;
   logic           done_q;

   // One-bit step in either direction; zero fill comes from the shift operators.
   assign right_step = data_reg >> 1;
   assign left_step  = data_reg << 1;

   mux_2x1 #(
      .N (N)
   ) u_step_mux (
      .i0 (right_step),
      .i1 (left_step),
      .s  (dir),
      .y  (step_val)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = (shift == '0) ? DONE : SHIFT;
            end
         end
         SHIFT: begin
            if (cnt == N'(1)) begin
               state_nxt = DONE;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // busy/done are registered from the next state so they line up exactly
   // with the state register rather than being decoded after it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         data_reg <= '0;
         cnt      <= '0;
         dir      <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state  <= state_nxt;
         busy_q <= (state_nxt != IDLE);
         done_q <= (state_nxt == DONE);
         case (state)
            IDLE: begin
               if (start) begin
                  data_reg <= num;
                  cnt      <= shift;
                  dir      <= select;
               end
            end
            SHIFT: begin
               data_reg <= step_val;
               cnt      <= cnt - N'(1);
            end
            default: ;
         endcase
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign result = data_reg;

endmodule : seq_shift_unit

// File: tb/tb_seq_shift_unit.sv
// tb_seq_shift_unit
//   Self-checking bench for seq_shift_unit (N = 3). A transaction-level
//   model predicts busy/done/result every cycle; directed cases pin
//   latency and final values with literal expectations.
module tb_seq_shift_unit;

   localparam int N = 3;
   localparam int W = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [W-1:0]  num;
   logic [N-1:0]  shift;
   logic          select;
   logic          busy;
   logic          done;
   logic [W-1:0]  result;

   int n_total = 0;
   int n_pass  = 0;

   always #5 clk = ~clk;

   seq_shift_unit #(
      .N (N)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .num    (num),
      .shift  (shift),
      .select (select),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
   endtask

   function automatic logic [W-1:0] shifted(input logic [W-1:0] v, input int k, input bit d);
      logic [W-1:0] r;
      r = d ? (v << k) : (v >> k);
      return r;
   endfunction

   // Transaction model: an operation lasts shift+1 output cycles; after k
   // of them the working value is the operand shifted by k places.
   bit           m_active  = 1'b0;
   int           m_elapsed = 0;
   int           m_sh      = 0;
   bit           m_dir     = 1'b0;
   logic [W-1:0] m_num     = '0;
   logic [W-1:0] m_res     = '0;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_active = 1'b0;
         m_res    = '0;
      end else if (m_active) begin
         if (m_elapsed == m_sh) begin
            m_active = 1'b0;
            m_res    = shifted(m_num, m_sh, m_dir);
         end else begin
            m_elapsed++;
         end
      end else if (start === 1'b1) begin
         m_active  = 1'b1;
         m_elapsed = 0;
         m_num     = num;
         m_sh      = int'(shift);
         m_dir     = select;
      end
   end

   always @(negedge clk) begin
      check("model busy", int'(busy), int'(m_active));
      check("model done", int'(done), int'(m_active && (m_elapsed == m_sh)));
      check("model result", int'(result),
            int'(m_active ? shifted(m_num, m_elapsed, m_dir) : m_res));
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Issues one operation from IDLE and checks latency, busy span and result.
   task automatic run_op(input logic [W-1:0] n, input int sh, input bit sel,
                         input logic [W-1:0] exp_res, input string name);
      int lat;
      int busy_cnt;
      bit got;
      start  = 1'b1;
      num    = n;
      shift  = N'(sh);
      select = sel;
      tick();
      start  = 1'b0;
      num    = W'($urandom);
      shift  = N'($urandom);
      select = 1'($urandom);
      lat = 0; busy_cnt = 0; got = 1'b0;
      for (int c = 1; c <= 40 && !got; c++) begin
         @(negedge clk);
         if (busy) busy_cnt++;
         if (done) begin
            got = 1'b1;
            lat = c;
            check({name, " result"}, int'(result), int'(exp_res));
         end
      end
      check({name, " latency"}, lat, sh + 1);
      check({name, " busy span"}, busy_cnt, sh + 1);
      tick();
   endtask

   initial begin
      int first_done;
      int second_done;
      int done_cnt;
      logic [W-1:0] res_at_done;

      reset = 1'b1; start = 1'b0; num = '0; shift = '0; select = 1'b0;
      repeat (2) @(negedge clk);
      check("reset busy", int'(busy), 0);
      check("reset done", int'(done), 0);
      check("reset result", int'(result), 0);
      tick();
      reset = 1'b0;
      tick();

      check("pin left", int'(shifted(8'hB1, 3, 1'b1)), 'h88);
      check("pin right", int'(shifted(8'hB1, 3, 1'b0)), 'h16);

      run_op(8'b1011_0001, 3, 1'b1, 8'b1000_1000, "b1 left3");
      run_op(8'b1011_0001, 3, 1'b0, 8'b0001_0110, "b1 right3");
      run_op(8'hA5, 0, 1'b0, 8'hA5, "a5 zero r");
      run_op(8'hA5, 0, 1'b1, 8'hA5, "a5 zero l");
      run_op(8'hFF, 7, 1'b1, 8'h80, "ff left7");
      run_op(8'hFF, 7, 1'b0, 8'h01, "ff right7");

      // start pulsed mid-operation must be ignored
      start = 1'b1; num = 8'hB1; shift = 3'd5; select = 1'b1;
      tick();
      start = 1'b0;
      tick();
      start = 1'b1; num = 8'h0F; shift = 3'd0;
      tick();
      start = 1'b0;
      done_cnt = 0; res_at_done = '0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (done) begin
            done_cnt++;
            res_at_done = result;
         end
      end
      check("ignore done count", done_cnt, 1);
      check("ignore result", int'(res_at_done), 'h20);
      check("ignore held", int'(result), 'h20);
      tick();

      // reset during an operation aborts it
      start = 1'b1; num = 8'hFF; shift = 3'd5; select = 1'b0;
      tick();
      start = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      #1;
      check("abort result", int'(result), 0);
      check("abort busy", int'(busy), 0);
      check("abort done", int'(done), 0);
      tick();
      reset = 1'b0;
      done_cnt = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (done) done_cnt++;
      end
      check("abort no done", done_cnt, 0);
      tick();
      run_op(8'h3C, 1, 1'b1, 8'h78, "post reset");

      // start held high: back-to-back every shift+2 cycles
      start = 1'b1; num = 8'h81; shift = 3'd2; select = 1'b0;
      tick();
      first_done = -1; second_done = -1;
      for (int c = 1; c <= 30 && second_done < 0; c++) begin
         @(negedge clk);
         if (done) begin
            check("held result", int'(result), 'h20);
            if (first_done < 0) first_done = c;
            else begin
               second_done = c;
               start = 1'b0;
            end
         end
      end
      start = 1'b0;
      check("held first latency", first_done, 3);
      check("held spacing", second_done - first_done, 4);
      tick();
      tick();

      // randomized traffic with inputs changing every cycle
      for (int c = 0; c < 1500; c++) begin
         start  = ($urandom_range(0, 2) == 0);
         num    = W'($urandom);
         shift  = N'($urandom);
         select = 1'($urandom);
         reset  = ($urandom_range(0, 299) == 0);
         tick();
      end
      reset = 1'b0;
      start = 1'b0;
      repeat (12) tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule : tb_seq_shift_unit

// File: doc/seq_shift_unit.md
SEQ_SHIFT_UNIT -- requirements
Module: seq_shift_unit

Interface
REQ-001 Parameter N, default 3, log2 of data width; data width W = 2**N.
REQ-002 clk  input  1  rising-edge clock; the block's only clock.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 num  input  W  operand; captured on accepted start.
REQ-006 shift  input  N  shift amount, 0..W-1; captured on accepted start.
REQ-007 select  input  1  direction; 0 = logical right, 1 = logical left; captured on accepted start.
REQ-008 busy  output  1  high in SHIFT and DONE states.
REQ-009 done  output  1  single-cycle pulse in DONE state.
REQ-010 result  output  W  shifted value; valid when done=1; held until next accepted start.

Function
REQ-011 FSM states SHALL be IDLE, SHIFT, DONE; the reset state is IDLE.
REQ-012 Start is accepted only when state=IDLE and start=1; the block SHALL ignore start in SHIFT and DONE.
REQ-013 On accept: data_reg<=num, cnt<=shift, dir<=select; next state = DONE if shift==0, else SHIFT.
REQ-014 SHIFT, each cycle: data_reg shifted one bit toward dir, zero-filled; cnt<=cnt-1; when cnt==1, next state = DONE.
REQ-015 DONE: done=1 for exactly one cycle; next state = IDLE unconditionally.
REQ-016 Latency: start accepted at edge t -> done high in cycle t+shift+1; shift=0 -> t+1.
REQ-017 The shift SHALL be logical: no rotate and no sign extension; bits shifted out are lost.
REQ-018 result SHALL equal data_reg at all times; final value = num>>shift (select=0) or (num<<shift) truncated to W (select=1).
REQ-019 Inputs num, shift and select MAY change after accept without affecting the operation in progress.
REQ-020 A start held high through DONE SHALL be accepted on the first IDLE cycle after DONE; back-to-back throughput is one operation per shift+2 cycles.

Reset
REQ-021 Assertion of reset SHALL asynchronously force state=IDLE, busy=0, done=0, result=0 and cnt=0, dir=0.
REQ-022 A reset mid-operation SHALL abort the operation; no done pulse is issued for it.
REQ-023 The first accepted start after reset deassertion SHALL behave as from power-up.

Structure
REQ-024 A shared package SHALL hold the state enum type (IDLE, SHIFT, DONE); W is derived locally from N.
REQ-025 The one-bit left/right step selection SHALL instantiate the existing mux_2x1 (parameter N) with i0 = right-step value, i1 = left-step value, s = dir.
REQ-026 Implementation target: 120-400 lines of RTL, single always_ff for the state and datapath, with separate combinational next-state logic.

Verification (N=3)
REQ-027 num=8'b1011_0001, shift=3, select=1, start at t -> done at t+4, result=8'b1000_1000, busy high t+1..t+4.
REQ-028 num=8'b1011_0001, shift=3, select=0 -> done at t+4, result=8'b0001_0110.
REQ-029 num=8'hA5, shift=0, either select -> done at t+1, result=8'hA5; SHIFT state never entered.
REQ-030 num=8'hFF, shift=7, select=1 -> done at t+8, result=8'h80; with select=0 -> result=8'h01.
REQ-031 Start pulsed with num=8'h0F during busy -> ignored; original result unchanged, exactly one done pulse.
REQ-032 Reset asserted in cycle t+2 of a shift=5 operation -> result=0, busy=0 immediately, no done; a following start with shift=1 -> correct done at t'+2.
